ddr3_mrs_sequencer: RTL and testbench
=====================================

Name: ddr3_mrs_sequencer

Overview:
Parametrised DDR3 power-up and mode-register sequencer for the DDR3 memory controller. It drives the JEDEC reset/CKE bring-up and the MRS programming of MR2, MR3, MR1 and MR0, derived from CL/CWL/WR/AL parameters. It then issues ZQCL and signals init_done. After init it accepts runtime mode-register rewrite requests over a valid/ready handshake. It sits between the controller's top-level state machine (RESET/INIT/IDLE) and the command/address output stage.

Parameters:
ADDR_W, 14, row/MRS address width (min 13)
BA_W, 3, bank address width
CL, 6, CAS latency, legal 5..11
CWL, 5, CAS write latency, legal 5..8
WR, 6, write recovery, legal 5,6,7,8,10,12,14,16
AL_MODE, 0, additive latency: 0=off, 1=CL-1, 2=CL-2
T_RESET, 8, cycles ddr_reset_n held low after rst_n release
T_CKE, 10, cycles from ddr_reset_n high to cke high, and from cke high to first MRS
T_MRD, 4, MRS-to-next-command spacing, min 2
T_MOD, 12, MR0/user-MRS-to-next-command spacing, min 2
T_ZQINIT, 16, ZQCL-to-init_done spacing, min 2

Ports:
clk  in  1  controller clock
rst_n  in  1  asynchronous active-low reset
ddr_reset_n  out  1  DRAM RESET#
cke  out  1  DRAM clock enable
cs_n  out  1  chip select
ras_n  out  1  row strobe
cas_n  out  1  column strobe
we_n  out  1  write enable
ba  out  BA_W  bank address (MR select)
addr  out  ADDR_W  address / mode-register payload
init_done  out  1  initialisation complete, sticky until reset
mr_req_valid  in  1  runtime MRS request
mr_req_ready  out  1  request accepted this cycle when valid&ready
mr_req_sel  in  2  target mode register 0..3
mr_req_data  in  ADDR_W  MRS payload

Behaviour:
- One clock, reset asynchronous active-low; all outputs registered.
- Reset values: ddr_reset_n=0, cke=0, {cs_n,ras_n,cas_n,we_n}=4'b0111 (NOP), ba=0, addr=0, init_done=0, mr_req_ready=0.
- Commands: NOP=0111; MRS=0000; ZQCL=0110 with addr[10]=1, other addr bits 0, ba=0.
- Each command is driven for exactly one cycle, then NOP until the spacing expires. Command-to-next-command distance is exactly the stated T_* in cycles.
- Unused upper addr bits are always 0.
- States and transitions:
  - RST_HOLD: ddr_reset_n=0 for T_RESET cycles after rst_n deasserts.
  - CKE_WAIT: ddr_reset_n=1; after T_CKE cycles cke=1.
  - MRS_WAIT: T_CKE further cycles, then go to MR2.
  - MR2: ba=2, addr[5:3]=CWL-5, rest 0. Then T_MRD.
  - MR3: ba=3, addr=0. Then T_MRD.
  - MR1: ba=1, addr[4:3]=AL_MODE, DLL enabled (addr[0]=0), rest 0. Then T_MRD.
  - MR0: ba=0, addr[6:4]=CL-4, addr[2]=0, addr[8]=1 (DLL reset), addr[11:9]=WR code (5→1,6→2,7→3,8→4,10→5,12→6,14→7,16→0), addr[1:0]=00 (BL8). Then T_MOD.
  - ZQCL: then T_ZQINIT; init_done=1 registered on the cycle the count expires.
  - IDLE: mr_req_ready=1.
  - USER_MRS: on valid&ready, capture sel/data. Next cycle issue MRS with ba=mr_req_sel, addr=mr_req_data; ready=0 from the accept cycle. After T_MOD, return to IDLE with ready=1.
- mr_req_valid before init_done: ready stays 0 and the request is held by the requester, then accepted in the first IDLE cycle. Back-to-back requests are spaced T_MOD apart.
- Elaboration fatal on an illegal parameter (CL, CWL, WR, AL_MODE out of range; T_MRD/T_MOD/T_ZQINIT<2; ADDR_W<13).
- Wait counter width is $clog2 of the largest T_* plus 1; no wrap within a wait.
- rst_n assertion at any time (mid-MRS, mid-wait, mid-request) immediately forces reset values and drops any pending request. The sequence restarts from RST_HOLD.

Test Plan:
- Defaults, rst_n released at cycle 0 → ddr_reset_n rises at cycle 8, cke at 18, MRS commands at 28 (ba=2), 32 (ba=3), 36 (ba=1), 40 (ba=0), ZQCL at 52, init_done at 68.
- Default payload check → MR2 addr=0x0000, MR1 addr=0x0000, MR0 addr=0x0520 (CL6→addr[6:4]=2, WR6→addr[11:9]=2, DLL reset addr[8]=1), ZQCL addr=0x0400.
- CL=11, CWL=8, WR=16, AL_MODE=2 → MR0 addr=0x0170, MR2 addr=0x0018, MR1 addr=0x0010.
- After init: mr_req_sel=1, data=0x0044, valid held → accept, MRS ba=1 addr=0x0044 next cycle. A second request is held with ready=0 and issued exactly 12 cycles after the first.
- mr_req_valid asserted at cycle 5 → ready=0 until init_done; accepted first IDLE cycle, MRS one cycle later.
- rst_n pulsed low during MR1 wait → outputs return to reset values asynchronously; full sequence repeats with the same timing relative to the new release.

Source files
------------

// File: rtl/ddr3_mrs_sequencer.sv
// DDR3 power-up/MRS sequencer: RESET#/CKE bring-up, MR2/MR3/MR1/MR0, ZQCL, then runtime MRS requests.
// All outputs registered; one wait counter times every command-to-command gap.
module ddr3_mrs_sequencer #(
  parameter int ADDR_W   = 14,
  parameter int BA_W     = 3,
  parameter int CL       = 6,
  parameter int CWL      = 5,
  parameter int WR       = 6,
  parameter int AL_MODE  = 0,
  parameter int T_RESET  = 8,
  parameter int T_CKE    = 10,
  parameter int T_MRD    = 4,
  parameter int T_MOD    = 12,
  parameter int T_ZQINIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ddr_reset_n,
  output logic              cke,
  output logic              cs_n,
  output logic              ras_n,
  output logic              cas_n,
  output logic              we_n,
  output logic [BA_W-1:0]   ba,
  output logic [ADDR_W-1:0] addr,
  output logic              init_done,
  input  logic              mr_req_valid,
  output logic              mr_req_ready,
  input  logic [1:0]        mr_req_sel,
  input  logic [ADDR_W-1:0] mr_req_data
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int wr_code(input int w);
    case (w)
      5: return 1;   6: return 2;   7: return 3;   8: return 4;
      10: return 5;  12: return 6;  14: return 7;  16: return 0;
      default: return -1;
    endcase
  endfunction

  localparam int T_MAX = imax(imax(imax(T_RESET, T_CKE), imax(T_MRD, T_MOD)), T_ZQINIT);
  localparam int CNT_W = $clog2(T_MAX) + 1;

  localparam logic [CNT_W-1:0] C_RESET  = CNT_W'(T_RESET);
  localparam logic [CNT_W-1:0] C_CKE    = CNT_W'(T_CKE);
  localparam logic [CNT_W-1:0] C_MRD    = CNT_W'(T_MRD);
  localparam logic [CNT_W-1:0] C_MOD    = CNT_W'(T_MOD);
  localparam logic [CNT_W-1:0] C_MOD_M2 = CNT_W'(T_MOD - 2);
  localparam logic [CNT_W-1:0] C_ZQ     = CNT_W'(T_ZQINIT);

  localparam logic [ADDR_W-1:0] MR2_VAL = ADDR_W'((CWL - 5) << 3);
  localparam logic [ADDR_W-1:0] MR1_VAL = ADDR_W'(AL_MODE << 3);
  localparam logic [ADDR_W-1:0] MR0_VAL = ADDR_W'((wr_code(WR) << 9) | (1 << 8) | ((CL - 4) << 4));
  localparam logic [ADDR_W-1:0] ZQ_VAL  = ADDR_W'(1 << 10);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ZQCL = 4'b0110;

  if (CL < 5 || CL > 11) begin : g_bad_cl
    $fatal(1, "ddr3_mrs_sequencer: illegal CL");
  end
  if (CWL < 5 || CWL > 8) begin : g_bad_cwl
    $fatal(1, "ddr3_mrs_sequencer: illegal CWL");
  end
  if (wr_code(WR) < 0) begin : g_bad_wr
    $fatal(1, "ddr3_mrs_sequencer: illegal WR");
  end
  if (AL_MODE < 0 || AL_MODE > 2) begin : g_bad_al
    $fatal(1, "ddr3_mrs_sequencer: illegal AL_MODE");
  end
  if (T_MRD < 2 || T_MOD < 2 || T_ZQINIT < 2) begin : g_bad_t
    $fatal(1, "ddr3_mrs_sequencer: T_MRD/T_MOD/T_ZQINIT must be >= 2");
  end
  if (ADDR_W < 13 || BA_W < 2) begin : g_bad_w
    $fatal(1, "ddr3_mrs_sequencer: ADDR_W must be >= 13 and BA_W >= 2");
  end

  typedef enum logic [3:0] {
    S_RST_HOLD, S_CKE_WAIT, S_MRS_WAIT, S_MR2, S_MR3, S_MR1, S_MR0,
    S_ZQCL, S_IDLE, S_USER_ISSUE, S_USER_WAIT
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                rstn_q, cke_q, done_q, rdy_q;
  logic [3:0]          cmd_q;
  logic [BA_W-1:0]     ba_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          sel_q;
  logic [ADDR_W-1:0]   data_q;

  // cnt_q is set to 1 on the cycle after each event, so it reads N exactly N cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST_HOLD;
      cnt_q   <= '0;
      rstn_q  <= 1'b0;
      cke_q   <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
      cmd_q   <= CMD_NOP;
      ba_q    <= '0;
      addr_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      cmd_q  <= CMD_NOP;
      ba_q   <= '0;
      addr_q <= '0;
      cnt_q  <= cnt_q + CNT_W'(1);
      case (state_q)
        S_RST_HOLD: if (cnt_q == C_RESET) begin
          rstn_q <= 1'b1; cnt_q <= CNT_W'(1); state_q <= S_CKE_WAIT;
        end
        S_CKE_WAIT: if (cnt_q == C_CKE) begin
          cke_q <= 1'b1; cnt_q <= CNT_W'(1); state_q <= S_MRS_WAIT;
        end
        S_MRS_WAIT: if (cnt_q == C_CKE) begin
          cmd_q <= CMD_MRS; ba_q <= BA_W'(2); addr_q <= MR2_VAL;
          cnt_q <= CNT_W'(1); state_q <= S_MR2;
        end
        S_MR2: if (cnt_q == C_MRD) begin
          cmd_q <= CMD_MRS; ba_q <= BA_W'(3);
          cnt_q <= CNT_W'(1); state_q <= S_MR3;
        end
        S_MR3: if (cnt_q == C_MRD) begin
          cmd_q <= CMD_MRS; ba_q <= BA_W'(1); addr_q <= MR1_VAL;
          cnt_q <= CNT_W'(1); state_q <= S_MR1;
        end
        S_MR1: if (cnt_q == C_MRD) begin
          cmd_q <= CMD_MRS; addr_q <= MR0_VAL;
          cnt_q <= CNT_W'(1); state_q <= S_MR0;
        end
        S_MR0: if (cnt_q == C_MOD) begin
          cmd_q <= CMD_ZQCL; addr_q <= ZQ_VAL;
          cnt_q <= CNT_W'(1); state_q <= S_ZQCL;
        end
        S_ZQCL: if (cnt_q == C_ZQ) begin
          done_q <= 1'b1; rdy_q <= 1'b1; state_q <= S_IDLE;
        end
        S_IDLE: begin
          cnt_q <= cnt_q;
          if (mr_req_valid && rdy_q) begin
            sel_q <= mr_req_sel; data_q <= mr_req_data;
            rdy_q <= 1'b0; state_q <= S_USER_ISSUE;
          end
        end
        S_USER_ISSUE: begin
          cmd_q <= CMD_MRS; ba_q <= BA_W'(sel_q); addr_q <= data_q;
          cnt_q <= CNT_W'(1);
          // Ready reopens two cycles early so a held request lands exactly T_MOD later.
          if (T_MOD == 2) begin
            rdy_q <= 1'b1; state_q <= S_IDLE;
          end else begin
            state_q <= S_USER_WAIT;
          end
        end
        S_USER_WAIT: if (cnt_q == C_MOD_M2) begin
          rdy_q <= 1'b1; state_q <= S_IDLE;
        end
        default: state_q <= S_RST_HOLD;
      endcase
    end
  end

  assign ddr_reset_n                  = rstn_q;
  assign cke                          = cke_q;
  assign {cs_n, ras_n, cas_n, we_n}   = cmd_q;
  assign ba                           = ba_q;
  assign addr                         = addr_q;
  assign init_done                    = done_q;
  assign mr_req_ready                 = rdy_q;

endmodule

// File: tb/tb_ddr3_mrs_sequencer.sv
// Directed table-driven bench for ddr3_mrs_sequencer: default-parameter DUT plus a CL11/CWL8/WR16/AL2 instance.
module tb_ddr3_mrs_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mr_req_valid;
  logic [1:0]  mr_req_sel;
  logic [13:0] mr_req_data;

  logic        ddr_reset_n, cke, cs_n, ras_n, cas_n, we_n, init_done, mr_req_ready;
  logic [2:0]  ba;
  logic [13:0] addr;

  logic        d2_ddr_reset_n, d2_cke, d2_cs_n, d2_ras_n, d2_cas_n, d2_we_n, d2_init_done, d2_ready;
  logic [2:0]  d2_ba;
  logic [13:0] d2_addr;

  always #5 clk = ~clk;

  ddr3_mrs_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ddr_reset_n(ddr_reset_n), .cke(cke),
    .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr), .init_done(init_done),
    .mr_req_valid(mr_req_valid), .mr_req_ready(mr_req_ready),
    .mr_req_sel(mr_req_sel), .mr_req_data(mr_req_data)
  );

  ddr3_mrs_sequencer #(.CL(11), .CWL(8), .WR(16), .AL_MODE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ddr_reset_n(d2_ddr_reset_n), .cke(d2_cke),
    .cs_n(d2_cs_n), .ras_n(d2_ras_n), .cas_n(d2_cas_n), .we_n(d2_we_n),
    .ba(d2_ba), .addr(d2_addr), .init_done(d2_init_done),
    .mr_req_valid(1'b0), .mr_req_ready(d2_ready),
    .mr_req_sel(2'b00), .mr_req_data(14'h0)
  );

  typedef struct {
    int          cyc;
    logic        vld;
    logic [1:0]  sel;
    logic [13:0] dat;
    logic        rstn;
    logic        cke;
    logic [3:0]  cmd;
    logic [2:0]  ba;
    logic [13:0] addr;
    logic        done;
    logic        rdy;
    logic [13:0] a2;
  } vec_t;

  vec_t vecs[$];
  int   cyc;
  int   checks = 0;
  int   failures = 0;

  localparam logic [3:0] NOP = 4'b0111, MRS = 4'b0000, ZQ = 4'b0110;

  task automatic add(input int c, input logic v, input logic [1:0] s, input logic [13:0] d,
                     input logic rn, input logic ck, input logic [3:0] cm, input logic [2:0] b,
                     input logic [13:0] a, input logic dn, input logic rd, input logic [13:0] a2);
    vec_t e;
    e.cyc = c; e.vld = v; e.sel = s; e.dat = d; e.rstn = rn; e.cke = ck; e.cmd = cm;
    e.ba = b; e.addr = a; e.done = dn; e.rdy = rd; e.a2 = a2;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_vectors(input int last);
    foreach (vecs[i]) begin
      if (vecs[i].cyc <= last) begin
        while (cyc < vecs[i].cyc) step();
        check("ddr_reset_n", ddr_reset_n, vecs[i].rstn);
        check("cke", cke, vecs[i].cke);
        check("cmd", {cs_n, ras_n, cas_n, we_n}, vecs[i].cmd);
        check("ba", ba, vecs[i].ba);
        check("addr", addr, vecs[i].addr);
        check("init_done", init_done, vecs[i].done);
        check("mr_req_ready", mr_req_ready, vecs[i].rdy);
        check("d2_addr", d2_addr, vecs[i].a2);
        check("d2_init_done", d2_init_done, vecs[i].done);
        check("d2_ready", d2_ready, vecs[i].done);
        check("d2_rst_cke", {d2_ddr_reset_n, d2_cke}, {vecs[i].rstn, vecs[i].cke});
        if (vecs[i].cyc < 69) begin
          check("d2_cmd", {d2_cs_n, d2_ras_n, d2_cas_n, d2_we_n}, vecs[i].cmd);
          check("d2_ba", d2_ba, vecs[i].ba);
        end else begin
          check("d2_cmd", {d2_cs_n, d2_ras_n, d2_cas_n, d2_we_n}, NOP);
          check("d2_ba", d2_ba, 3'd0);
        end
        mr_req_valid = vecs[i].vld;
        mr_req_sel   = vecs[i].sel;
        mr_req_data  = vecs[i].dat;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ddr_reset_n"}, ddr_reset_n, 1'b0);
    check({tag, "_cke"}, cke, 1'b0);
    check({tag, "_cmd"}, {cs_n, ras_n, cas_n, we_n}, NOP);
    check({tag, "_ba"}, ba, 3'd0);
    check({tag, "_addr"}, addr, 14'h0);
    check({tag, "_init_done"}, init_done, 1'b0);
    check({tag, "_ready"}, mr_req_ready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    //  cyc vld sel dat      rstn cke cmd  ba  addr     done rdy a2
    add(0,  0, 0, 14'h000,  0, 0, NOP, 0, 14'h000, 0, 0, 14'h000);
    add(5,  1, 1, 14'h044,  0, 0, NOP, 0, 14'h000, 0, 0, 14'h000);
    add(7,  1, 1, 14'h044,  0, 0, NOP, 0, 14'h000, 0, 0, 14'h000);
    add(8,  1, 1, 14'h044,  1, 0, NOP, 0, 14'h000, 0, 0, 14'h000);
    add(17, 1, 1, 14'h044,  1, 0, NOP, 0, 14'h000, 0, 0, 14'h000);
    add(18, 1, 1, 14'h044,  1, 1, NOP, 0, 14'h000, 0, 0, 14'h000);
    add(27, 1, 1, 14'h044,  1, 1, NOP, 0, 14'h000, 0, 0, 14'h000);
    add(28, 1, 1, 14'h044,  1, 1, MRS, 2, 14'h000, 0, 0, 14'h018);
    add(29, 1, 1, 14'h044,  1, 1, NOP, 0, 14'h000, 0, 0, 14'h000);
    add(31, 1, 1, 14'h044,  1, 1, NOP, 0, 14'h000, 0, 0, 14'h000);
    add(32, 1, 1, 14'h044,  1, 1, MRS, 3, 14'h000, 0, 0, 14'h000);
    add(35, 1, 1, 14'h044,  1, 1, NOP, 0, 14'h000, 0, 0, 14'h000);
    add(36, 1, 1, 14'h044,  1, 1, MRS, 1, 14'h000, 0, 0, 14'h010);
    add(40, 1, 1, 14'h044,  1, 1, MRS, 0, 14'h520, 0, 0, 14'h170);
    add(41, 1, 1, 14'h044,  1, 1, NOP, 0, 14'h000, 0, 0, 14'h000);
    add(51, 1, 1, 14'h044,  1, 1, NOP, 0, 14'h000, 0, 0, 14'h000);
    add(52, 1, 1, 14'h044,  1, 1, ZQ,  0, 14'h400, 0, 0, 14'h400);
    add(67, 1, 1, 14'h044,  1, 1, NOP, 0, 14'h000, 0, 0, 14'h000);
    add(68, 1, 1, 14'h044,  1, 1, NOP, 0, 14'h000, 1, 1, 14'h000);
    add(69, 1, 3, 14'h123,  1, 1, NOP, 0, 14'h000, 1, 0, 14'h000);
    add(70, 1, 3, 14'h123,  1, 1, MRS, 1, 14'h044, 1, 0, 14'h000);
    add(79, 1, 3, 14'h123,  1, 1, NOP, 0, 14'h000, 1, 0, 14'h000);
    add(80, 1, 3, 14'h123,  1, 1, NOP, 0, 14'h000, 1, 1, 14'h000);
    add(81, 0, 0, 14'h000,  1, 1, NOP, 0, 14'h000, 1, 0, 14'h000);
    add(82, 0, 0, 14'h000,  1, 1, MRS, 3, 14'h123, 1, 0, 14'h000);
    add(91, 0, 0, 14'h000,  1, 1, NOP, 0, 14'h000, 1, 0, 14'h000);
    add(92, 0, 0, 14'h000,  1, 1, NOP, 0, 14'h000, 1, 1, 14'h000);
    add(93, 0, 0, 14'h000,  1, 1, NOP, 0, 14'h000, 1, 1, 14'h000);

    rst_n = 1'b0; mr_req_valid = 1'b0; mr_req_sel = 2'd0; mr_req_data = 14'h0;
    cyc = -100;
    repeat (3) step();
    check_reset_values("por");

    rst_n = 1'b1; cyc = -1;
    run_vectors(1000);

    // Asynchronous reset after init, then a second reset pulse in the MR1 wait.
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_idle");
    step();
    rst_n = 1'b1; cyc = -1;
    run_vectors(36);
    step(); step();
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_mr1");
    step();
    rst_n = 1'b1; cyc = -1;
    run_vectors(1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
